// File: rtl/conv_window_addr_gen.sv
// Sliding-window address generator: walks oy, ox, ky, kx and streams image,
// kernel and output-pixel addresses over a valid/ready port, start/done framed.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin a frame pass (sampled in IDLE only)
//   busy                      frame in progress
//   done                      one-cycle pulse after the final beat handshake
//   addr_valid, addr_ready    output beat handshake
//   im_addr                   image pixel address
//   k_addr                    kernel coefficient address
//   filt_addr                 output pixel address
//   win_first, win_last       first / last beat of a window
module conv_window_addr_gen #(
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int KER_SIZE = 3,
  parameter int STRIDE   = 1,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [ADDR_W-1:0] k_addr,
  output logic [ADDR_W-1:0] filt_addr,
  output logic              win_first,
  output logic              win_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int OUT_W = (IMG_W - KER_SIZE) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - KER_SIZE) / STRIDE + 1;

  localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(KER_SIZE - 1);
  localparam logic [ADDR_W-1:0] OW_LAST = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] OH_LAST = ADDR_W'(OUT_H - 1);

  // Constant strides between successive kernel rows, windows and window rows.
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] WIN_STEP  = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(STRIDE * IMG_W);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] kx_q, kx_d;
  logic [ADDR_W-1:0] ky_q, ky_d;
  logic [ADDR_W-1:0] ox_q, ox_d;
  logic [ADDR_W-1:0] oy_q, oy_d;

  // row: start of current kernel row; win: window origin; line: row of windows.
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] win_q, win_d;
  logic [ADDR_W-1:0] line_q, line_d;

  logic [ADDR_W-1:0] im_q, im_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] filt_q, filt_d;

  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic first_q, first_d;
  logic last_q, last_d;

  logic kx_end, ky_end, ox_end, oy_end, win_end;
  logic step_kx, step_ky, step_ox, step_oy, frame_end;

  assign kx_end  = (kx_q == K_LAST);
  assign ky_end  = (ky_q == K_LAST);
  assign ox_end  = (ox_q == OW_LAST);
  assign oy_end  = (oy_q == OH_LAST);
  assign win_end = kx_end && ky_end;

  // Mutually exclusive advance cases, innermost loop first.
  assign step_kx   = !kx_end;
  assign step_ky   = kx_end && !ky_end;
  assign step_ox   = win_end && !ox_end;
  assign step_oy   = win_end && ox_end && !oy_end;
  assign frame_end = win_end && ox_end && oy_end;

  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    row_d   = row_q;
    win_d   = win_q;
    line_d  = line_q;
    im_d    = im_q;
    k_d     = k_q;
    filt_d  = filt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          kx_d    = '0;
          ky_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
          row_d   = '0;
          win_d   = '0;
          line_d  = '0;
          im_d    = '0;
          k_d     = '0;
          filt_d  = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (addr_ready) begin
          unique case (1'b1)
            step_kx: begin
              kx_d = kx_q + 1'b1;
              im_d = im_q + 1'b1;
              k_d  = k_q + 1'b1;
            end
            step_ky: begin
              kx_d  = '0;
              ky_d  = ky_q + 1'b1;
              row_d = row_q + ROW_STEP;
              im_d  = row_q + ROW_STEP;
              k_d   = k_q + 1'b1;
            end
            step_ox: begin
              kx_d   = '0;
              ky_d   = '0;
              ox_d   = ox_q + 1'b1;
              win_d  = win_q + WIN_STEP;
              row_d  = win_q + WIN_STEP;
              im_d   = win_q + WIN_STEP;
              k_d    = '0;
              filt_d = filt_q + 1'b1;
            end
            step_oy: begin
              kx_d   = '0;
              ky_d   = '0;
              ox_d   = '0;
              oy_d   = oy_q + 1'b1;
              line_d = line_q + LINE_STEP;
              win_d  = line_q + LINE_STEP;
              row_d  = line_q + LINE_STEP;
              im_d   = line_q + LINE_STEP;
              k_d    = '0;
              filt_d = filt_q + 1'b1;
            end
            frame_end: begin
              state_d = S_DONE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              im_d    = '0;
              k_d     = '0;
              filt_d  = '0;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flags follow the registered loop indices of the beat being presented.
    if (state_d == S_RUN) begin
      first_d = (kx_d == '0) && (ky_d == '0);
      last_d  = (kx_d == K_LAST) && (ky_d == K_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      row_q   <= '0;
      win_q   <= '0;
      line_q  <= '0;
      im_q    <= '0;
      k_q     <= '0;
      filt_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      row_q   <= row_d;
      win_q   <= win_d;
      line_q  <= line_d;
      im_q    <= im_d;
      k_q     <= k_d;
      filt_q  <= filt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign addr_valid = valid_q;
  assign im_addr    = im_q;
  assign k_addr     = k_q;
  assign filt_addr  = filt_q;
  assign win_first  = first_q;
  assign win_last   = last_q;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench for conv_window_addr_gen: three configurations checked beat by beat
// against a nested-loop reference model, with random backpressure.
module tb_conv_window_addr_gen;

  typedef struct packed {
    logic [15:0] im;
    logic [15:0] k;
    logic [15:0] filt;
    logic        first;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b1;
  int   sel = 0;

  logic        busy [3];
  logic        done [3];
  logic        valid[3];
  logic        first[3];
  logic        last [3];
  logic [15:0] im   [3];
  logic [15:0] ka   [3];
  logic [15:0] fa   [3];

  int PW[3] = '{5, 5, 4};
  int PH[3] = '{5, 5, 4};
  int PK[3] = '{3, 3, 1};
  int PS[3] = '{1, 2, 1};

  int n_vec = 0;
  int n_err = 0;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  conv_window_addr_gen #(
    .IMG_W(5), .IMG_H(5), .KER_SIZE(3), .STRIDE(1), .ADDR_W(16)
  ) u_a (
    .clk(clk), .rst(rst), .start(start && sel == 0),
    .busy(busy[0]), .done(done[0]),
    .addr_valid(valid[0]), .addr_ready(ready),
    .im_addr(im[0]), .k_addr(ka[0]), .filt_addr(fa[0]),
    .win_first(first[0]), .win_last(last[0])
  );

  conv_window_addr_gen #(
    .IMG_W(5), .IMG_H(5), .KER_SIZE(3), .STRIDE(2), .ADDR_W(16)
  ) u_b (
    .clk(clk), .rst(rst), .start(start && sel == 1),
    .busy(busy[1]), .done(done[1]),
    .addr_valid(valid[1]), .addr_ready(ready),
    .im_addr(im[1]), .k_addr(ka[1]), .filt_addr(fa[1]),
    .win_first(first[1]), .win_last(last[1])
  );

  conv_window_addr_gen #(
    .IMG_W(4), .IMG_H(4), .KER_SIZE(1), .STRIDE(1), .ADDR_W(16)
  ) u_c (
    .clk(clk), .rst(rst), .start(start && sel == 2),
    .busy(busy[2]), .done(done[2]),
    .addr_valid(valid[2]), .addr_ready(ready),
    .im_addr(im[2]), .k_addr(ka[2]), .filt_addr(fa[2]),
    .win_first(first[2]), .win_last(last[2])
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: enumerate the frame with plain nested loops.
  function automatic void fill(int w, int h, int k, int s);
    int ow, oh;
    beat_t b;
    exp_q.delete();
    ow = (w - k) / s + 1;
    oh = (h - k) / s + 1;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            b.im    = 16'((oy * s + ky) * w + ox * s + kx);
            b.k     = 16'(ky * k + kx);
            b.filt  = 16'(oy * ow + ox);
            b.first = (kx == 0) && (ky == 0);
            b.last  = (kx == k - 1) && (ky == k - 1);
            exp_q.push_back(b);
          end
  endfunction

  function automatic beat_t sample(int s);
    beat_t b;
    b.im    = im[s];
    b.k     = ka[s];
    b.filt  = fa[s];
    b.first = first[s];
    b.last  = last[s];
    return b;
  endfunction

  task automatic run_frame(input int s, input bit bp, input bit spam);
    int    idx;
    int    cyc;
    bit    stalled;
    beat_t prev;
    beat_t cur;
    sel = s;
    fill(PW[s], PH[s], PK[s], PS[s]);
    @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = spam;
    chk("busy_on", 64'(busy[s]), 64'd1);
    chk("first_valid", 64'(valid[s]), 64'd1);
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    prev = '0;
    while (idx < exp_q.size() && cyc < 4000) begin
      cur = sample(s);
      chk("valid_run", 64'(valid[s]), 64'd1);
      chk("no_early_done", 64'(done[s]), 64'd0);
      if (stalled) chk("hold", 64'(cur), 64'(prev));
      ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (ready) begin
        chk($sformatf("beat%0d", idx), 64'(cur), 64'(exp_q[idx]));
        idx++;
        stalled = 1'b0;
      end else begin
        prev = cur;
        stalled = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 4000) chk("timeout", 64'd0, 64'd1);
    chk("beat_count", 64'(idx), 64'(exp_q.size()));
    chk("done_pulse", 64'(done[s]), 64'd1);
    chk("done_valid", 64'(valid[s]), 64'd0);
    chk("done_busy", 64'(busy[s]), 64'd0);
    start = spam;
    @(negedge clk);
    start = 1'b0;
    chk("done_once", 64'(done[s]), 64'd0);
    chk("idle_valid", 64'(valid[s]), 64'd0);
    @(negedge clk);
    chk("idle_stay", 64'(valid[s]), 64'd0);
    chk("idle_busy", 64'(busy[s]), 64'd0);
    ready = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("rst_valid", 64'(valid[s]), 64'd0);
      chk("rst_busy", 64'(busy[s]), 64'd0);
      chk("rst_done", 64'(done[s]), 64'd0);
      chk("rst_addr", 64'({im[s], ka[s], fa[s]}), 64'd0);
      chk("rst_flags", 64'({first[s], last[s]}), 64'd0);
    end

    run_frame(0, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b0);
    run_frame(0, 1'b0, 1'b1);
    run_frame(0, 1'b0, 1'b0);

    // Abort a frame with reset after 40 accepted beats.
    sel = 0;
    fill(PW[0], PH[0], PK[0], PS[0]);
    @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("pre_rst%0d", i), 64'(sample(0)), 64'(exp_q[i]));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 64'(valid[0]), 64'd0);
    chk("mid_rst_busy", 64'(busy[0]), 64'd0);
    chk("mid_rst_addr", 64'({im[0], ka[0], fa[0]}), 64'd0);
    chk("mid_rst_flags", 64'({first[0], last[0]}), 64'd0);
    chk("mid_rst_done", 64'(done[0]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", 64'(done[0]), 64'd0);
      chk("post_rst_valid", 64'(valid[0]), 64'd0);
    end
    run_frame(0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
